// File: rtl/pec_streamer_sink_pkg.sv
// Shared types for the PEC streamer sink: FSM state encoding and the
// current/next state pair used by the control logic.
package pec_package;

    typedef enum logic [1:0] {
        SNK_READY        = 2'd0,
        SNK_BUSY         = 2'd1,
        SNK_BUFF_OUTPUT  = 2'd2,
        SNK_STORE_OUTPUT = 2'd3
    } pec_streamer_sink_fsm_e;

    typedef struct packed {
        pec_streamer_sink_fsm_e curr_state;
        pec_streamer_sink_fsm_e next_state;
    } pec_snk_fsm_state_t;

endpackage

// File: rtl/pec_streamer_sink_addr_gen.sv
// Vector/word counters and running byte address for the streamer sink;
// the address is accumulated so no multiplier sits in the request path.
module pec_sink_addr_gen #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16,
    parameter int WORDS  = 8,
    parameter int BYTES  = 4,
    parameter int WC_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [CNT_W-1:0]  n_vectors_i,
    input  logic              clr_word_i,
    input  logic              word_adv_i,
    input  logic              vec_adv_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [WC_W-1:0]   word_cnt_o,
    output logic              last_word_o,
    output logic              last_vector_o,
    output logic              n_zero_o
);

    localparam logic [WC_W-1:0]   LAST_WORD = WC_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0] WORD_INC  = ADDR_W'(BYTES);

    logic [ADDR_W-1:0] r_stride;
    logic [ADDR_W-1:0] r_vec_base;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_n_vectors;
    logic [CNT_W-1:0]  r_vec_cnt;
    logic [WC_W-1:0]   r_word_cnt;
    logic [ADDR_W-1:0] w_next_vec_base;

    // Adders wrap modulo 2^ADDR_W by construction.
    assign w_next_vec_base = r_vec_base + r_stride;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stride    <= '0;
            r_vec_base  <= '0;
            r_addr      <= '0;
            r_n_vectors <= '0;
            r_vec_cnt   <= '0;
            r_word_cnt  <= '0;
        end else if (init_i) begin
            r_stride    <= stride_i;
            r_vec_base  <= base_i;
            r_addr      <= base_i;
            r_n_vectors <= n_vectors_i;
            r_vec_cnt   <= '0;
            r_word_cnt  <= '0;
        end else if (vec_adv_i) begin
            r_vec_cnt   <= r_vec_cnt + 1'b1;
            r_vec_base  <= w_next_vec_base;
            r_addr      <= w_next_vec_base;
            r_word_cnt  <= '0;
        end else if (word_adv_i) begin
            r_word_cnt  <= r_word_cnt + 1'b1;
            r_addr      <= r_addr + WORD_INC;
        end else if (clr_word_i) begin
            r_word_cnt  <= '0;
            r_addr      <= r_vec_base;
        end
    end

    // Comparing against n-1 keeps vec_cnt within CNT_W even for n = 2^CNT_W-1.
    assign addr_o        = r_addr;
    assign word_cnt_o    = r_word_cnt;
    assign last_word_o   = (r_word_cnt == LAST_WORD);
    assign last_vector_o = (r_vec_cnt == (r_n_vectors - 1'b1));
    assign n_zero_o      = (r_n_vectors == '0);

endmodule

// File: rtl/pec_streamer_sink.sv
// PEC streamer sink: buffers one array output vector, then writes it out as
// DATA_W words over a req/gnt port. Optional ReLU at capture: PEC_SNK_RELU_EN.
module pec_streamer_sink
    import pec_package::*;
#(
    parameter int N_COLS = 32,
    parameter int ELEM_W = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [ADDR_W-1:0]        cfg_base_addr_i,
    input  logic [ADDR_W-1:0]        cfg_stride_i,
    input  logic [CNT_W-1:0]         cfg_n_vectors_i,
    output logic                     busy_o,
    output logic                     done_o,
    input  logic                     vec_valid_i,
    output logic                     vec_ready_o,
    input  logic [N_COLS*ELEM_W-1:0] vec_data_i,
    output logic                     mem_req_o,
    input  logic                     mem_gnt_i,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [DATA_W-1:0]        mem_wdata_o,
    output logic                     mem_we_o,
    output logic [DATA_W/8-1:0]      mem_be_o
);

    localparam int VEC_W = N_COLS * ELEM_W;
    localparam int WORDS = VEC_W / DATA_W;
    localparam int BYTES = DATA_W / 8;
    localparam int WC_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

    pec_streamer_sink_fsm_e r_state;
    pec_snk_fsm_state_t     w_fsm;
    logic [VEC_W-1:0]       r_buf;
    logic [VEC_W-1:0]       w_captured;
    logic                   r_done;

    logic                   w_start, w_accept, w_gnt, w_word_adv, w_vec_adv;
    logic [ADDR_W-1:0]      w_addr;
    logic [WC_W-1:0]        w_word_cnt;
    logic                   w_last_word, w_last_vector, w_n_zero;

    assign w_start    = (r_state == SNK_READY) && start_i;
    assign w_accept   = (r_state == SNK_BUFF_OUTPUT) && vec_valid_i;
    assign w_gnt      = (r_state == SNK_STORE_OUTPUT) && mem_gnt_i;
    assign w_word_adv = w_gnt && !w_last_word;
    assign w_vec_adv  = w_gnt && w_last_word;

    pec_sink_addr_gen #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .WORDS  (WORDS),
        .BYTES  (BYTES),
        .WC_W   (WC_W)
    ) u_addr_gen (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .init_i        (w_start),
        .base_i        (cfg_base_addr_i),
        .stride_i      (cfg_stride_i),
        .n_vectors_i   (cfg_n_vectors_i),
        .clr_word_i    (w_accept),
        .word_adv_i    (w_word_adv),
        .vec_adv_i     (w_vec_adv),
        .addr_o        (w_addr),
        .word_cnt_o    (w_word_cnt),
        .last_word_o   (w_last_word),
        .last_vector_o (w_last_vector),
        .n_zero_o      (w_n_zero)
    );

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves it unassigned and no latch is inferred.
    always_comb begin
        w_fsm.curr_state = r_state;
        w_fsm.next_state = r_state;
        case (r_state)
            SNK_READY:        if (start_i) w_fsm.next_state = SNK_BUSY;
            SNK_BUSY:         w_fsm.next_state = w_n_zero ? SNK_READY : SNK_BUFF_OUTPUT;
            SNK_BUFF_OUTPUT:  if (vec_valid_i) w_fsm.next_state = SNK_STORE_OUTPUT;
            SNK_STORE_OUTPUT: if (mem_gnt_i && w_last_word)
                                  w_fsm.next_state = w_last_vector ? SNK_READY : SNK_BUFF_OUTPUT;
        endcase
    end

    always_comb begin
        w_captured = vec_data_i;
`ifdef PEC_SNK_RELU_EN
        for (int k = 0; k < N_COLS; k++) begin
            if (vec_data_i[k*ELEM_W + ELEM_W-1]) w_captured[k*ELEM_W +: ELEM_W] = '0;
        end
`endif
    end

    // NOTE: the vector buffer is a plain register bank, so it can take the
    // async reset; a RAM-mapped buffer would be left unreset instead.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= SNK_READY;
            r_buf   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_fsm.next_state;
            r_done  <= ((r_state == SNK_BUSY) && w_n_zero) || (w_vec_adv && w_last_vector);
            if (w_accept) r_buf <= w_captured;
        end
    end

    // Memory-side outputs are zero whenever no request is outstanding.
    assign busy_o      = (w_fsm.curr_state != SNK_READY);
    assign done_o      = r_done;
    assign vec_ready_o = (w_fsm.curr_state == SNK_BUFF_OUTPUT);
    assign mem_req_o   = (w_fsm.curr_state == SNK_STORE_OUTPUT);
    assign mem_we_o    = mem_req_o;
    assign mem_be_o    = {BYTES{mem_req_o}};
    assign mem_addr_o  = mem_req_o ? w_addr : '0;
    assign mem_wdata_o = mem_req_o ? r_buf[int'(w_word_cnt)*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_pec_streamer_sink.sv
// Self-checking bench for pec_streamer_sink: scoreboard of expected memory
// writes filled at vector acceptance and drained at each granted request.
module tb_pec_streamer_sink;

    localparam int N_COLS = 32;
    localparam int ELEM_W = 8;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 16;
    localparam int VEC_W  = N_COLS * ELEM_W;
    localparam int WORDS  = VEC_W / DATA_W;
    localparam int BYTES  = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              start_i = 1'b0;
    logic [ADDR_W-1:0] cfg_base_addr_i = '0;
    logic [ADDR_W-1:0] cfg_stride_i = '0;
    logic [CNT_W-1:0]  cfg_n_vectors_i = '0;
    logic              busy_o, done_o;
    logic              vec_valid_i = 1'b0;
    logic              vec_ready_o;
    logic [VEC_W-1:0]  vec_data_i = '0;
    logic              mem_req_o;
    logic              mem_gnt_i = 1'b0;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_we_o;
    logic [BYTES-1:0]  mem_be_o;

    pec_streamer_sink #(
        .N_COLS(N_COLS), .ELEM_W(ELEM_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .start_i         (start_i),
        .cfg_base_addr_i (cfg_base_addr_i),
        .cfg_stride_i    (cfg_stride_i),
        .cfg_n_vectors_i (cfg_n_vectors_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .vec_valid_i     (vec_valid_i),
        .vec_ready_o     (vec_ready_o),
        .vec_data_i      (vec_data_i),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_addr_o      (mem_addr_o),
        .mem_wdata_o     (mem_wdata_o),
        .mem_we_o        (mem_we_o),
        .mem_be_o        (mem_be_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    wr_t               sb[$];
    logic [VEC_W-1:0]  vec_tbl [0:3];
    logic [ADDR_W-1:0] job_base, job_stride;
    int                cyc = 0;
    int                vec_idx, n_drive, words_seen, done_cnt, done_cyc, busy_cycles;
    int                accept_cyc, first_req_cyc, last_gnt_cyc, ready_during_req, stall_left;
    bit                gnt_random, prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_data, first_word;

    // Reference packing: word w holds bytes w*BYTES .. w*BYTES+3, little-endian.
    function automatic logic [DATA_W-1:0] exp_word(input logic [VEC_W-1:0] v, input int w);
        logic [DATA_W-1:0] r;
        logic [7:0]        b;
        r = '0;
        for (int i = 0; i < BYTES; i++) begin
            b = v[(w*BYTES + i)*8 +: 8];
`ifdef PEC_SNK_RELU_EN
            if (b[7]) b = 8'h00;
`endif
            r[i*8 +: 8] = b;
        end
        return r;
    endfunction

    // One cycle: called at a negedge, observes outputs, decides gnt/valid
    // for the coming posedge, then advances to the next negedge.
    task automatic tick();
        bit  g;
        wr_t e;
        vec_valid_i = (vec_idx < n_drive);
        vec_data_i  = vec_valid_i ? vec_tbl[vec_idx & 3] : '0;
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (busy_o) busy_cycles++;
        if (mem_req_o && vec_ready_o) ready_during_req++;
        if (mem_req_o && first_req_cyc < 0) first_req_cyc = cyc;
        if (prev_stall) begin
            checks++;
            if (!mem_req_o || mem_addr_o !== prev_addr || mem_wdata_o !== prev_data) begin
                errors++;
                $display("FAIL stall_stable: req=%0b addr=%h data=%h required req=1 addr=%h data=%h",
                         mem_req_o, mem_addr_o, mem_wdata_o, prev_addr, prev_data);
            end
        end
        if (!gnt_random)          g = 1'b1;
        else if (!mem_req_o)      g = 1'b0;
        else if (stall_left == 0) begin g = 1'b1; stall_left = $urandom_range(0, 5); end
        else                      begin g = 1'b0; stall_left--; end
        mem_gnt_i = g;
        if (mem_req_o && g) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: addr=%h data=%h required no write", mem_addr_o, mem_wdata_o);
            end else begin
                e = sb.pop_front();
                if (mem_addr_o !== e.addr || mem_wdata_o !== e.data || mem_we_o !== 1'b1 || mem_be_o !== {BYTES{1'b1}}) begin
                    errors++;
                    $display("FAIL write_%0d: addr=%h data=%h we=%0b be=%h required addr=%h data=%h we=1 be=%h",
                             words_seen, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o, e.addr, e.data, {BYTES{1'b1}});
                end
            end
            if (words_seen == 0) first_word = mem_wdata_o;
            words_seen++;
            last_gnt_cyc = cyc;
        end
        prev_stall = mem_req_o && !g;
        prev_addr  = mem_addr_o;
        prev_data  = mem_wdata_o;
        if (vec_valid_i && vec_ready_o) begin
            for (int w = 0; w < WORDS; w++)
                sb.push_back('{addr: job_base + ADDR_W'(vec_idx) * job_stride + ADDR_W'(w * BYTES),
                               data: exp_word(vec_tbl[vec_idx & 3], w)});
            if (accept_cyc < 0) accept_cyc = cyc;
            vec_idx++;
        end
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic run_job(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                           input int n, input bit rnd, input int abort_at, output bit aborted);
        job_base = base; job_stride = stride; n_drive = n; gnt_random = rnd;
        vec_idx = 0; words_seen = 0; done_cnt = 0; done_cyc = -1; busy_cycles = 0;
        accept_cyc = -1; first_req_cyc = -1; last_gnt_cyc = -1; ready_during_req = 0;
        prev_stall = 1'b0; stall_left = $urandom_range(0, 5); aborted = 1'b0;
        sb.delete();
        cfg_base_addr_i = base; cfg_stride_i = stride; cfg_n_vectors_i = CNT_W'(n);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        // Scramble config after start: the sink must use its latched copy.
        cfg_base_addr_i = 32'hDEAD_0000; cfg_stride_i = 32'h0000_0004; cfg_n_vectors_i = 16'd9;
        for (int i = 0; i < 2000 && done_cnt == 0; i++) begin
            if (abort_at >= 0 && words_seen == abort_at && mem_req_o) begin
                aborted = 1'b1;
                return;
            end
            start_i = (words_seen == 2);
            tick();
        end
        start_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (done_cnt != 1) begin errors++; $display("FAIL done_pulses: got %0d required 1", done_cnt); end
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL writes_missing: %0d left required 0", sb.size()); end
        checks++;
        if (ready_during_req != 0) begin errors++; $display("FAIL ready_in_store: %0d cycles required 0", ready_during_req); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL idle_after_job: busy=%0b required 0", busy_o); end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, vec_ready_o, mem_req_o, mem_we_o} !== 5'b0 || mem_addr_o !== '0 ||
            mem_wdata_o !== '0 || mem_be_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%0b done=%0b rdy=%0b req=%0b addr=%h required all 0",
                     busy_o, done_o, vec_ready_o, mem_req_o, mem_addr_o);
        end
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_single();
        bit ab;
        for (int k = 0; k < N_COLS; k++) vec_tbl[0][k*8 +: 8] = 8'(k);
        run_job(32'h1000, 32'h20, 1, 1'b0, -1, ab);
        checks++;
        if (words_seen != WORDS) begin errors++; $display("FAIL single_words: got %0d required %0d", words_seen, WORDS); end
        checks++;
        if (first_word !== 32'h0302_0100) begin errors++; $display("FAIL single_first_word: got %h required 03020100", first_word); end
        checks++;
        if (first_req_cyc - accept_cyc != 1) begin
            errors++; $display("FAIL accept_to_req: got %0d cycles required 1", first_req_cyc - accept_cyc);
        end
        checks++;
        if (done_cyc - last_gnt_cyc != 1) begin
            errors++; $display("FAIL gnt_to_done: got %0d cycles required 1", done_cyc - last_gnt_cyc);
        end
    endtask

    task automatic test_back_to_back();
        bit ab;
        for (int v = 0; v < 3; v++)
            for (int k = 0; k < N_COLS; k++) vec_tbl[v][k*8 +: 8] = 8'($urandom);
        run_job(32'h2000, 32'h100, 3, 1'b0, -1, ab);
        checks++;
        if (words_seen != 3 * WORDS) begin errors++; $display("FAIL multi_words: got %0d required %0d", words_seen, 3 * WORDS); end
        checks++;
        if (first_req_cyc < 0 || last_gnt_cyc - first_req_cyc < 3 * WORDS - 1) begin
            errors++; $display("FAIL multi_span: got %0d cycles required >= %0d", last_gnt_cyc - first_req_cyc, 3 * WORDS - 1);
        end
    endtask

    task automatic test_stalls();
        bit ab;
        for (int v = 0; v < 2; v++)
            for (int k = 0; k < N_COLS; k++) vec_tbl[v][k*8 +: 8] = 8'($urandom);
        // Base near the top of the address space so the second vector wraps.
        run_job(32'hFFFF_FFF0, 32'h10, 2, 1'b1, -1, ab);
        checks++;
        if (words_seen != 2 * WORDS) begin errors++; $display("FAIL stall_words: got %0d required %0d", words_seen, 2 * WORDS); end
    endtask

    task automatic test_zero_vectors();
        bit ab;
        run_job(32'h5000, 32'h40, 0, 1'b0, -1, ab);
        checks++;
        if (busy_cycles != 1) begin errors++; $display("FAIL zero_busy: got %0d cycles required 1", busy_cycles); end
        checks++;
        if (first_req_cyc != -1 || words_seen != 0) begin
            errors++; $display("FAIL zero_no_req: got %0d writes required 0", words_seen);
        end
    endtask

    task automatic test_reset_mid_job();
        bit ab;
        for (int v = 0; v < 3; v++)
            for (int k = 0; k < N_COLS; k++) vec_tbl[v][k*8 +: 8] = 8'($urandom);
        run_job(32'h3000, 32'h40, 3, 1'b0, WORDS + 3, ab);
        checks++;
        if (!ab) begin errors++; $display("FAIL abort_point: got not reached required reached"); end
        checks++;
        if (mem_addr_o !== 32'h3000 + 32'h40 + 32'(3 * BYTES)) begin
            errors++; $display("FAIL abort_addr: got %h required %h", mem_addr_o, 32'h3000 + 32'h40 + 32'(3 * BYTES));
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_o, done_o, vec_ready_o, mem_req_o, mem_we_o} !== 5'b0 || mem_addr_o !== '0 ||
            mem_wdata_o !== '0 || mem_be_o !== '0) begin
            errors++;
            $display("FAIL abort_outputs: busy=%0b done=%0b req=%0b addr=%h data=%h required all 0",
                     busy_o, done_o, mem_req_o, mem_addr_o, mem_wdata_o);
        end
        mem_gnt_i = 1'b0; vec_valid_i = 1'b0; n_drive = 0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: done=%0b busy=%0b required 0 0", done_o, busy_o);
        end
        run_job(32'h3000, 32'h40, 2, 1'b0, -1, ab);
        checks++;
        if (words_seen != 2 * WORDS) begin errors++; $display("FAIL restart_words: got %0d required %0d", words_seen, 2 * WORDS); end
    endtask

    task automatic test_relu();
        bit                ab;
        logic [DATA_W-1:0] want;
        for (int k = 0; k < N_COLS; k++) vec_tbl[0][k*8 +: 8] = 8'(k);
        vec_tbl[0][7:0]  = 8'h80;
        vec_tbl[0][15:8] = 8'h7F;
`ifdef PEC_SNK_RELU_EN
        want = 32'h0302_7F00;
`else
        want = 32'h0302_7F80;
`endif
        run_job(32'h6000, 32'h20, 1, 1'b0, -1, ab);
        checks++;
        if (first_word !== want) begin errors++; $display("FAIL relu_word: got %h required %h", first_word, want); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stalls();
        test_zero_vectors();
        test_reset_mid_job();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
